// File: rtl/gyro_frame_asm.sv
// Gyro burst-frame assembler: packs six big-endian bytes into X/Y/Z rates, calibrates
// a zero-rate bias over 2^CAL_SHIFT frames, then emits bias-corrected saturated samples.
// Optional feature: define GYRO_DEADBAND_EN to zero outputs with |corr| <= DEADBAND.
module gyro_frame_asm #(
  parameter int CAL_SHIFT = 4,
  parameter int DEADBAND  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  input  logic               frame_start,
  input  logic               cal_req,
  output logic signed [15:0] pitch_gyro,
  output logic signed [15:0] roll_gyro,
  output logic signed [15:0] yaw_gyro,
  output logic               gyro_oe,
  output logic               cal_done,
  output logic               frame_err
);
  localparam int AW   = 16 + CAL_SHIFT;
  localparam int NFRM = 1 << CAL_SHIFT;

  typedef enum logic {S_CAL, S_RUN} state_t;

  // Byte assembly
  logic [4:0][7:0] buf_q, buf_d;
  logic [2:0]      idx_q, idx_d;
  logic            open_q, open_d;
  logic            err_q, err_d;
  logic            fvld_q, fvld_d;
  logic [2:0][15:0] raw_q, raw_d;

  // Calibration / run datapath
  state_t          state_q, state_d;
  logic [2:0][AW-1:0] acc_q, acc_d;
  logic [2:0][15:0] bias_q, bias_d;
  logic [2:0][15:0] out_q, out_d;
  logic [CAL_SHIFT:0] fcnt_q, fcnt_d, fcnt_inc;
  logic            oe_q, oe_d;
  logic            cdone_q, cdone_d;
  logic            cal_last;

  logic signed [AW-1:0] acc_sum [3];
  logic [15:0]          bias_new [3];
  logic signed [16:0]   corr [3];
  logic [15:0]          res [3];

  function automatic logic [15:0] sat16(input logic signed [16:0] c);
    if (c[16] != c[15]) return c[16] ? 16'h8000 : 16'h7FFF;
    return c[15:0];
  endfunction

`ifdef GYRO_DEADBAND_EN
  localparam logic signed [15:0] DB = 16'(DEADBAND);
  function automatic logic [15:0] shape(input logic [15:0] s);
    if ($signed(s) >= -DB && $signed(s) <= DB) return 16'h0000;
    return s;
  endfunction
`else
  function automatic logic [15:0] shape(input logic [15:0] s);
    return s;
  endfunction
`endif

  always_comb begin
    buf_d  = buf_q;
    idx_d  = idx_q;
    open_d = open_q;
    err_d  = 1'b0;
    fvld_d = 1'b0;
    raw_d  = raw_q;
    if (byte_valid) begin
      if (frame_start) begin
        // open implies idx in 1..5, so a restart here always aborts a partial frame
        err_d    = open_q;
        buf_d[0] = byte_in;
        idx_d    = 3'd1;
        open_d   = 1'b1;
      end else if (open_q) begin
        if (idx_q == 3'd5) begin
          fvld_d = ~cal_req;
          raw_d  = {{buf_q[4], byte_in}, {buf_q[2], buf_q[3]}, {buf_q[0], buf_q[1]}};
          idx_d  = 3'd0;
          open_d = 1'b0;
        end else begin
          buf_d[idx_q] = byte_in;
          idx_d        = idx_q + 3'd1;
        end
      end
    end
  end

  for (genvar a = 0; a < 3; a++) begin : g_ax
    assign acc_sum[a]  = $signed(acc_q[a]) + $signed({{CAL_SHIFT{raw_q[a][15]}}, raw_q[a]});
    assign bias_new[a] = 16'(acc_sum[a] >>> CAL_SHIFT);
    assign corr[a]     = $signed({raw_q[a][15], raw_q[a]}) - $signed({bias_q[a][15], bias_q[a]});
    assign res[a]      = shape(sat16(corr[a]));
  end

  assign fcnt_inc = fcnt_q + 1'b1;
  assign cal_last = (fcnt_inc == NFRM[CAL_SHIFT:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_CAL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cal_req)                                   state_d = S_CAL;
    else if (state_q == S_CAL && fvld_q && cal_last) state_d = S_RUN;
  end

  always_comb begin
    acc_d   = acc_q;
    bias_d  = bias_q;
    out_d   = out_q;
    fcnt_d  = fcnt_q;
    cdone_d = cdone_q;
    oe_d    = 1'b0;
    if (cal_req) begin
      acc_d   = '0;
      fcnt_d  = '0;
      cdone_d = 1'b0;
    end else if (fvld_q) begin
      if (state_q == S_CAL) begin
        if (cal_last) begin
          for (int a = 0; a < 3; a++) bias_d[a] = bias_new[a];
          cdone_d = 1'b1;
          acc_d   = '0;
          fcnt_d  = '0;
        end else begin
          for (int a = 0; a < 3; a++) acc_d[a] = acc_sum[a];
          fcnt_d = fcnt_inc;
        end
      end else begin
        for (int a = 0; a < 3; a++) out_d[a] = res[a];
        oe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= '0;
      idx_q   <= '0;
      open_q  <= 1'b0;
      err_q   <= 1'b0;
      fvld_q  <= 1'b0;
      raw_q   <= '0;
      acc_q   <= '0;
      bias_q  <= '0;
      out_q   <= '0;
      fcnt_q  <= '0;
      oe_q    <= 1'b0;
      cdone_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      open_q  <= open_d;
      err_q   <= err_d;
      fvld_q  <= fvld_d;
      raw_q   <= raw_d;
      acc_q   <= acc_d;
      bias_q  <= bias_d;
      out_q   <= out_d;
      fcnt_q  <= fcnt_d;
      oe_q    <= oe_d;
      cdone_q <= cdone_d;
    end
  end

  assign roll_gyro  = out_q[0];
  assign pitch_gyro = out_q[1];
  assign yaw_gyro   = out_q[2];
  assign gyro_oe    = oe_q;
  assign cal_done   = cdone_q;
  assign frame_err  = err_q;
endmodule

// File: tb/tb_gyro_frame_asm.sv
// Scoreboard bench for gyro_frame_asm: stimulus pushes expected samples, a negedge
// monitor pops one per gyro_oe strobe and checks values and latency.
module tb_gyro_frame_asm;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        cal_req = 1'b0;
  logic signed [15:0] pitch_gyro, roll_gyro, yaw_gyro;
  logic        gyro_oe, cal_done, frame_err;

  gyro_frame_asm #(.CAL_SHIFT(4), .DEADBAND(2)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .frame_start(frame_start), .cal_req(cal_req), .pitch_gyro(pitch_gyro),
    .roll_gyro(roll_gyro), .yaw_gyro(yaw_gyro), .gyro_oe(gyro_oe),
    .cal_done(cal_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r, p, y;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0, n_err = 0, cyc = 0, last_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) n_err++;
      if (gyro_oe) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_oe: cyc %0d roll %0d pitch %0d yaw %0d, no sample expected",
                   cyc, roll_gyro, pitch_gyro, yaw_gyro);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (roll_gyro !== e.r || pitch_gyro !== e.p || yaw_gyro !== e.y || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL sample: got r/p/y %0d/%0d/%0d at cyc %0d, want %0d/%0d/%0d at cyc %0d",
                     roll_gyro, pitch_gyro, yaw_gyro, cyc,
                     $signed(e.r), $signed(e.p), $signed(e.y), e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b, input logic fs, input logic cr);
    byte_in = b; byte_valid = 1'b1; frame_start = fs; cal_req = cr;
    @(posedge clk); #1;
    byte_valid = 1'b0; frame_start = 1'b0; cal_req = 1'b0;
    last_edge = cyc;
  endtask

  task automatic send_tail(input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] z, input logic cr);
    drive(x[7:0], 1'b0, 1'b0);
    drive(y[15:8], 1'b0, 1'b0);
    drive(y[7:0], 1'b0, 1'b0);
    drive(z[15:8], 1'b0, 1'b0);
    drive(z[7:0], 1'b0, cr);
  endtask

  task automatic send_frame(input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] z, input logic cr);
    drive(x[15:8], 1'b1, 1'b0);
    send_tail(x, y, z, cr);
  endtask

  task automatic expect_out(input logic [15:0] r, input logic [15:0] p, input logic [15:0] y);
    exp_t e;
    e.r = r; e.p = p; e.y = y; e.cyc = last_edge + 1;
    q.push_back(e);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_roll", int'(roll_gyro), 0);
    chk("reset_pitch", int'(pitch_gyro), 0);
    chk("reset_yaw", int'(yaw_gyro), 0);
    chk("reset_cal_done", int'(cal_done), 0);
    chk("reset_oe", int'(gyro_oe), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Calibration: bias becomes 16, -8, 0
    for (int i = 0; i < 16; i++) begin
      send_frame(16'h0010, 16'hFFF8, 16'h0000, 1'b0);
      if (i == 14) chk("cal_done_before_16", int'(cal_done), 0);
    end
    chk("cal_done_at_edge_N", int'(cal_done), 0);
    @(posedge clk); #1;
    chk("cal_done_rise", int'(cal_done), 1);

    send_frame(16'h0110, 16'h0000, 16'h0064, 1'b0);
    expect_out(16'd256, 16'd8, 16'd100);
    // Positive and negative saturation
    send_frame(16'h8000, 16'h7FFF, 16'h0000, 1'b0);
    expect_out(16'h8000, 16'h7FFF, 16'h0000);

    // Aborted frame: 3 bytes, then a fresh frame_start
    drive(8'h12, 1'b1, 1'b0);
    drive(8'h34, 1'b0, 1'b0);
    drive(8'h56, 1'b0, 1'b0);
    drive(8'h00, 1'b1, 1'b0);
    chk("frame_err_pulse", int'(frame_err), 1);
    send_tail(16'h0020, 16'h0000, 16'hFFFF, 1'b0);
    expect_out(16'd16, 16'd8, 16'hFFFF);
    @(posedge clk); #1;
    chk("frame_err_count", n_err, 1);

    // Back-to-back frames; cal_req on the sixth byte of the second drops it
    send_frame(16'h0011, 16'hFFF9, 16'h0001, 1'b0);
    expect_out(16'd1, 16'd1, 16'd1);
    send_frame(16'h1234, 16'h1234, 16'h1234, 1'b1);
    chk("cal_done_drop", int'(cal_done), 0);
    for (int i = 0; i < 16; i++) begin
      send_frame(16'h0000, 16'h0000, 16'h0000, 1'b0);
      if (i == 14) chk("recal_not_done_15", int'(cal_done), 0);
    end
    @(posedge clk); #1;
    chk("recal_done", int'(cal_done), 1);

    // Stray byte with no open frame is ignored
    drive(8'hAA, 1'b0, 1'b0);
    send_frame(16'h0002, 16'hFFFE, 16'h0003, 1'b0);
`ifdef GYRO_DEADBAND_EN
    expect_out(16'd0, 16'd0, 16'd3);
`else
    expect_out(16'd2, 16'hFFFE, 16'd3);
`endif
    send_frame(16'h8000, 16'h0001, 16'h7FFF, 1'b0);
`ifdef GYRO_DEADBAND_EN
    expect_out(16'h8000, 16'd0, 16'h7FFF);
`else
    expect_out(16'h8000, 16'd1, 16'h7FFF);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    chk("frame_err_total", n_err, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gyro_frame_asm.md
# gyro_frame_asm

Assembles the 6-byte gyroscope burst read from the IMU (GYRO_XOUT_H..GYRO_ZOUT_L) into signed 16-bit pitch, roll and yaw rate samples. Removes a per-axis zero-rate bias measured at start-up and emits one corrected sample per frame with a single-cycle strobe. It sits between the I2C burst reader and the gyro integrator, and drives that integrator's sample inputs and its enable strobe.

## Interface
- CAL_SHIFT, 4: calibration averages 2^CAL_SHIFT frames; legal range 1..8.
- DEADBAND, 2: magnitude threshold for the optional deadband.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- byte_in  in  8  data byte from the burst reader.
- byte_valid  in  1  byte_in is valid this cycle.
- frame_start  in  1  qualifies byte_valid; marks byte 0 (GYRO_XOUT_H) of a frame.
- cal_req  in  1  single-cycle pulse that restarts bias calibration.
- pitch_gyro  out  16 signed  bias-corrected Y-axis rate.
- roll_gyro  out  16 signed  bias-corrected X-axis rate.
- yaw_gyro  out  16 signed  bias-corrected Z-axis rate.
- gyro_oe  out  1  one-cycle strobe; the three outputs are new and valid.
- cal_done  out  1  high once the bias is valid.
- frame_err  out  1  one-cycle pulse when a frame is aborted.

## Operation
- Byte order: big-endian per axis, in the sequence X_H, X_L, Y_H, Y_L, Z_H, Z_L.
- Axis mapping: X to roll, Y to pitch, Z to yaw.
- Byte counter idx is 0..5 and "open" is a flag.
  - byte_valid with frame_start: the byte is stored as idx 0, open is set, and idx becomes 1.
  - byte_valid without frame_start while open: the byte is stored at idx and idx increments.
  - byte_valid without frame_start while not open: the byte is dropped silently.
  - frame_start while open with idx 1..5: frame_err pulses, the partial frame is discarded, and the new byte becomes idx 0.
  - Sixth byte accepted: the frame is complete, open clears, and idx returns to 0.
- State machine CAL / RUN; reset enters CAL.
  - CAL: each complete frame adds its raw sign-extended value to acc_x/acc_y/acc_z, each (16+CAL_SHIFT) bits signed. Frame counter fcnt increments.
  - CAL exit: when fcnt reaches 2^CAL_SHIFT, bias_a = acc_a >>> CAL_SHIFT (arithmetic shift, truncation toward minus infinity). Then cal_done is set, and the accumulators and fcnt clear. Go to RUN.
  - During CAL, gyro_oe stays 0 and the outputs hold their values.
  - RUN: each complete frame computes corr = raw - bias in 17-bit signed. corr is saturated to [-32768, 32767], registered to the outputs, and gyro_oe pulses.
  - cal_req in any state: clears the accumulators, fcnt and cal_done, and goes to CAL. The bias and the outputs keep their values. A frame completing in the same cycle as cal_req is discarded.
- Reset values: all outputs 0, bias 0, accumulators 0, idx 0, open 0, state CAL.

## Timing
- Sixth byte sampled at edge N; outputs and gyro_oe are updated at edge N+1 (latency 1). gyro_oe is high for exactly one cycle.
- Bytes may arrive back to back, one per cycle, with no minimum gap between frames. Frame_start on the cycle after a sixth byte is legal.
- In CAL, cal_done rises at edge N+1 of the 2^CAL_SHIFT-th frame. The first RUN sample is the next complete frame.
- frame_err is asserted at the edge after the offending frame_start.
- rst asserted at any time returns the block immediately to its reset values. Any partial frame is lost.

## Configuration
- GYRO_DEADBAND_EN defined: in RUN, a saturated corr with |corr| <= DEADBAND is output as 0. Latency is unchanged.
- GYRO_DEADBAND_EN undefined: no deadband logic; the saturated corr is output directly.

## Test plan
- Reset then 16 frames with X=0x0010, Y=0xFFF8, Z=0x0000 -> no gyro_oe; cal_done rises after frame 16; bias = 16, -8, 0.
- After that calibration, frame X=0x0110, Y=0x0000, Z=0x0064 -> gyro_oe one cycle after the sixth byte; roll=256, pitch=8, yaw=100.
- After that calibration, frame Y=0x7FFF -> pitch=32767 (saturated). With bias 0 on X, frame X=0x8000 -> roll=-32768.
- Send 3 bytes, then frame_start with a full valid frame -> frame_err pulses once; only the second frame produces gyro_oe, with correct values.
- Send back-to-back frames with no gaps, and cal_req coinciding with a sixth byte -> that frame produces no gyro_oe; cal_done drops; recalibration takes 16 further frames.
- With GYRO_DEADBAND_EN, bias 0, frame X=0x0002, Y=0xFFFE, Z=0x0003 -> roll=0, pitch=0, yaw=3. Without the macro -> 2, -2, 3.
